hilo_acc_file: RTL and testbench

Parametrised HI/LO special-register file for the dual-issue MIPS core. It generalises the single-lane HI/LO register with independent HI and LO write enables per issue lane (MTHI/MTLO), and per-half forwarding from every M and W lane. It adds a two-stage multiply-accumulate engine (MADD/MADDU/MSUB/MSUBU) with a busy/done handshake and a flush input. It sits beside the E stage: MF* instructions read `hilo_o` in E, and the ALU launches accumulate operations from E.

---
 rtl/hilo_acc_file.sv | 107 ++++++++++
 tb/tb_hilo_acc_file.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_acc_file.sv
// HI/LO register file with per-lane M/W forwarding (0-cycle reads) and a 3-cycle multiply-accumulate engine.
// No backpressure: accumulate accepts only in IDLE and raises acc_busy so the core stalls younger instructions.
module hilo_acc_file #(
   parameter int W     = 32,
   parameter int LANES = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [LANES-1:0]       M_we_hi,
   input  logic [LANES-1:0]       M_we_lo,
   input  logic [LANES*2*W-1:0]   M_hilo,
   input  logic [LANES-1:0]       W_we_hi,
   input  logic [LANES-1:0]       W_we_lo,
   input  logic [LANES*2*W-1:0]   W_hilo,
   input  logic                   acc_start,
   input  logic [1:0]             acc_op,
   input  logic [W-1:0]           acc_a,
   input  logic [W-1:0]           acc_b,
   input  logic                   acc_flush,
   output logic                   acc_busy,
   output logic                   acc_done,
   output logic [2*W-1:0]         hilo_o
);

   localparam int DW = 2 * W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MUL    = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   hilo_q, hilo_d;
   logic [DW-1:0]   prod_q, prod_d;
   logic            op_sub_q, op_sub_d;

   logic [W-1:0]    wr_hi, wr_lo;
   logic [W-1:0]    fwd_hi, fwd_lo;
   logic [DW-1:0]   base;
   logic [DW-1:0]   ext_a, ext_b, prod_mul;

   // Ascending lane scan: the last (youngest) enabled lane overwrites older ones.
   always_comb begin
      wr_hi = hilo_q[DW-1:W];
      wr_lo = hilo_q[W-1:0];
      for (int k = 0; k < LANES; k++) begin
         if (W_we_hi[k]) wr_hi = W_hilo[k*DW+W +: W];
         if (W_we_lo[k]) wr_lo = W_hilo[k*DW +: W];
      end
      fwd_hi = wr_hi;
      fwd_lo = wr_lo;
      for (int k = 0; k < LANES; k++) begin
         if (M_we_hi[k]) fwd_hi = M_hilo[k*DW+W +: W];
         if (M_we_lo[k]) fwd_lo = M_hilo[k*DW +: W];
      end
   end

   assign base   = {fwd_hi, fwd_lo};
   assign hilo_o = base;

   // Signed vs unsigned only differs in how operands are extended; the low 2W bits of the product are then identical.
   assign ext_a    = acc_op[0] ? {{W{1'b0}}, acc_a} : {{W{acc_a[W-1]}}, acc_a};
   assign ext_b    = acc_op[0] ? {{W{1'b0}}, acc_b} : {{W{acc_b[W-1]}}, acc_b};
   assign prod_mul = ext_a * ext_b;

   always_comb begin
      state_d  = state_q;
      prod_d   = prod_q;
      op_sub_d = op_sub_q;
      hilo_d   = {wr_hi, wr_lo};
      case (state_q)
         IDLE: begin
            if (acc_start && !acc_flush) begin
               state_d  = MUL;
               prod_d   = prod_mul;
               op_sub_d = acc_op[1];
            end
         end
         MUL:    state_d = acc_flush ? IDLE : COMMIT;
         COMMIT: begin
            state_d = IDLE;
            // Younger than any W write this cycle; base already folds that write in.
            if (!acc_flush) hilo_d = op_sub_q ? (base - prod_q) : (base + prod_q);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         hilo_q   <= '0;
         prod_q   <= '0;
         op_sub_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         hilo_q   <= hilo_d;
         prod_q   <= prod_d;
         op_sub_q <= op_sub_d;
      end
   end

   assign acc_busy = (state_q == MUL) || (state_q == COMMIT);
   assign acc_done = (state_q == COMMIT) && !acc_flush;

endmodule

// File: tb/tb_hilo_acc_file.sv
// Bench for hilo_acc_file: directed scenarios then random traffic against a cycle-indexed reference model.
module tb_hilo_acc_file;
   localparam int W     = 32;
   localparam int LANES = 2;
   localparam int DW    = 2 * W;

   logic                  clk;
   logic                  rst_n;
   logic [LANES-1:0]      M_we_hi, M_we_lo, W_we_hi, W_we_lo;
   logic [LANES*DW-1:0]   M_hilo, W_hilo;
   logic                  acc_start, acc_flush;
   logic [1:0]            acc_op;
   logic [W-1:0]          acc_a, acc_b;
   logic                  acc_busy, acc_done;
   logic [DW-1:0]         hilo_o;

   hilo_acc_file #(.W(W), .LANES(LANES)) dut (
      .clk(clk), .rst_n(rst_n),
      .M_we_hi(M_we_hi), .M_we_lo(M_we_lo), .M_hilo(M_hilo),
      .W_we_hi(W_we_hi), .W_we_lo(W_we_lo), .W_hilo(W_hilo),
      .acc_start(acc_start), .acc_op(acc_op), .acc_a(acc_a), .acc_b(acc_b),
      .acc_flush(acc_flush), .acc_busy(acc_busy), .acc_done(acc_done),
      .hilo_o(hilo_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            pass_cnt  = 0;
   int            total_cnt = 0;
   int            cyc       = 0;
   logic [DW-1:0] ref_reg   = '0;
   logic          active    = 1'b0;
   int            commit_at = 0;
   logic [DW-1:0] m_prod    = '0;
   logic          m_sub     = 1'b0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total_cnt++;
      assert (obs === exp) begin
         pass_cnt = pass_cnt + 1;
      end else begin
         $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Youngest enabled lane per half, searched from the top lane down.
   function automatic logic [DW-1:0] pick(input logic [LANES-1:0] we_hi, input logic [LANES-1:0] we_lo,
                                          input logic [LANES*DW-1:0] dat, input logic [DW-1:0] fallback);
      logic [W-1:0] hi, lo;
      logic hi_found, lo_found;
      hi = fallback[DW-1:W]; lo = fallback[W-1:0];
      hi_found = 1'b0; lo_found = 1'b0;
      for (int k = LANES - 1; k >= 0; k--) begin
         if (!hi_found && we_hi[k]) begin hi = dat[k*DW+W +: W]; hi_found = 1'b1; end
         if (!lo_found && we_lo[k]) begin lo = dat[k*DW +: W];   lo_found = 1'b1; end
      end
      return {hi, lo};
   endfunction

   function automatic logic [DW-1:0] product(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      longint p;
      if (op[0]) p = longint'({32'b0, a}) * longint'({32'b0, b});
      else       p = longint'($signed(a)) * longint'($signed(b));
      return p;
   endfunction

   // Check this cycle's outputs, advance the model, then move to the next falling edge.
   task automatic tick();
      logic [DW-1:0] wres, e_hilo, nxt;
      logic e_done;
      #1;
      if (!rst_n) begin ref_reg = '0; active = 1'b0; end
      wres   = pick(W_we_hi, W_we_lo, W_hilo, ref_reg);
      e_hilo = pick(M_we_hi, M_we_lo, M_hilo, wres);
      e_done = active && (cyc == commit_at) && !acc_flush;
      chk("hilo_o", hilo_o, e_hilo);
      chk("acc_busy", {63'b0, acc_busy}, {63'b0, active});
      chk("acc_done", {63'b0, acc_done}, {63'b0, e_done});
      if (rst_n) begin
         nxt = wres;
         if (active) begin
            if (acc_flush) active = 1'b0;
            else if (cyc == commit_at) begin
               nxt = m_sub ? (e_hilo - m_prod) : (e_hilo + m_prod);
               active = 1'b0;
            end
         end else if (acc_start && !acc_flush) begin
            active    = 1'b1;
            commit_at = cyc + 2;
            m_prod    = product(acc_op, acc_a, acc_b);
            m_sub     = acc_op[1];
         end
         ref_reg = nxt;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic idle_in();
      M_we_hi = '0; M_we_lo = '0; W_we_hi = '0; W_we_lo = '0;
      M_hilo = '0; W_hilo = '0;
      acc_start = 1'b0; acc_flush = 1'b0; acc_op = 2'd0; acc_a = '0; acc_b = '0;
   endtask

   task automatic w_both(input logic [DW-1:0] v);
      W_we_hi = 2'b01; W_we_lo = 2'b01; W_hilo[0 +: DW] = v;
   endtask

   task automatic start(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      acc_start = 1'b1; acc_op = op; acc_a = a; acc_b = b;
   endtask

   initial begin
      idle_in();
      rst_n = 1'b0;
      tick(); tick();
      #1 chk("reset_hilo", hilo_o, 64'h0);
      chk("reset_busy", {63'b0, acc_busy}, 64'h0);
      rst_n = 1'b1;
      tick();

      // W lane0 write, visible next cycle from the register
      w_both(64'h11111111_22222222);
      tick();
      idle_in();
      #1 chk("w_store", hilo_o, 64'h11111111_22222222);
      tick();

      // lane and half priority
      M_we_hi = 2'b11;
      M_hilo[0 +: DW]  = {32'h0000000A, 32'h0};
      M_hilo[DW +: DW] = {32'h0000000B, 32'h0};
      W_we_lo = 2'b10;
      W_hilo[DW +: DW] = {32'h0, 32'h0000000C};
      #1 chk("prio_fwd", hilo_o, {32'h0000000B, 32'h0000000C});
      tick();
      idle_in();
      #1 chk("prio_store", hilo_o, {32'h11111111, 32'h0000000C});
      tick();

      // signed MADD
      w_both(64'h10);
      tick();
      idle_in();
      start(2'd0, 32'hFFFFFFFE, 32'd3);
      tick();
      idle_in();
      #1 chk("madd_busy1", {63'b0, acc_busy}, 64'h1);
      tick();
      #1 chk("madd_done", {63'b0, acc_done}, 64'h1);
      chk("madd_base", hilo_o, 64'h10);
      tick();
      #1 chk("madd_res", hilo_o, 64'h0000000A);
      chk("madd_idle", {63'b0, acc_busy}, 64'h0);
      tick();

      // MSUBU wrap-around
      w_both(64'h0);
      tick();
      idle_in();
      start(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
      tick();
      idle_in();
      tick(); tick();
      #1 chk("msubu_res", hilo_o, 64'h00000001_FFFFFFFF);
      tick();

      // commit merges a same-cycle W write; start during MUL ignored
      w_both(64'h0);
      tick();
      idle_in();
      start(2'd1, 32'd2, 32'd2);
      tick();
      start(2'd0, 32'd7, 32'd7);
      tick();
      idle_in();
      W_we_lo = 2'b01; W_hilo[0 +: DW] = 64'h5;
      tick();
      idle_in();
      #1 chk("merge_res", hilo_o, 64'h9);
      chk("merge_nobusy", {63'b0, acc_busy}, 64'h0);
      tick();

      // flush in COMMIT
      start(2'd0, 32'd5, 32'd5);
      tick();
      idle_in();
      tick();
      acc_flush = 1'b1;
      #1 chk("flush_nodone", {63'b0, acc_done}, 64'h0);
      tick();
      idle_in();
      #1 chk("flush_hold", hilo_o, 64'h9);
      tick();

      // async reset mid-operation
      start(2'd1, 32'd3, 32'd3);
      tick();
      idle_in();
      rst_n = 1'b0;
      #1 chk("arst_busy", {63'b0, acc_busy}, 64'h0);
      chk("arst_hilo", hilo_o, 64'h0);
      tick();
      rst_n = 1'b1;
      tick(); tick();
      #1 chk("arst_nocommit", hilo_o, 64'h0);
      tick();

      // random traffic
      for (int i = 0; i < 600; i++) begin
         for (int k = 0; k < LANES; k++) begin
            M_we_hi[k] = ($urandom_range(0, 5) == 0);
            M_we_lo[k] = ($urandom_range(0, 5) == 0);
            W_we_hi[k] = ($urandom_range(0, 3) == 0);
            W_we_lo[k] = ($urandom_range(0, 3) == 0);
            M_hilo[k*DW +: DW] = {$urandom, $urandom};
            W_hilo[k*DW +: DW] = {$urandom, $urandom};
         end
         acc_start = ($urandom_range(0, 2) == 0);
         acc_flush = ($urandom_range(0, 11) == 0);
         acc_op    = 2'($urandom_range(0, 3));
         acc_a     = $urandom;
         acc_b     = $urandom;
         tick();
      end

      idle_in();
      tick();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
